dump_datapath: RTL
==================

Name: dump_datapath

Overview:
- Output-side counterpart of the load datapath. Captures a squeezed rate block from the Keccak state and serializes it into w-bit words on a valid/ready stream.
- Byte order and endianness on the output match the input convention of the load side.
- Tracks the remaining requested output length. Masks the final partial word. Requests further squeeze blocks from the core controller until the requested length has been emitted.

Parameters:
- W, default w (64): output word width in bits.
- RATE, default RATE_SHAKE128 (1344): width of captured rate block in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- size_load  in  1  latch output_size and mode; accepted only in IDLE.
- output_size  in  32  requested output length in bits; bits [2:0] are ignored and treated as 0.
- operation_mode  in  2  SHAKE128_MODE_VEC or SHAKE256_MODE_VEC.
- block_valid  in  1  state_in holds a fresh permutation result.
- state_in  in  RATE  rate portion of the state, lane 0 at bits [63:0].
- data_out_ready  in  1  downstream sink ready.
- data_out  out  W  output word; first stream byte at [W-1:W-8].
- data_out_valid  out  1  data_out is valid.
- valid_bytes  out  4  number of valid bytes in data_out, 1..8; reads 0 when data_out_valid=0.
- last_output_word  out  1  current word is the final word of the request.
- block_request  out  1  one-cycle pulse requesting the next squeeze block.
- busy  out  1  asserted whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the final word transfers.

Behaviour:
- Reset (asynchronous, rst=0):
  - FSM goes to IDLE.
  - All counters and the buffer clear to 0.
  - All outputs are 0.
- FSM states: IDLE, WAIT_BLOCK, SHIFT, DONE.
- IDLE:
  - On size_load, latch remaining = {output_size[31:3], 3'b000} and latch the mode.
  - If remaining == 0, go to DONE. Otherwise go to WAIT_BLOCK.
  - block_valid is ignored in IDLE.
- WAIT_BLOCK:
  - On block_valid, load state_in into the PISO buffer.
  - Set word_counter = max_words: 21 for SHAKE128, 17 for SHAKE256; unknown modes use 21.
  - Go to SHIFT. data_out_valid rises the next cycle (1-cycle load latency).
- SHIFT:
  - data_out = EndianSwitcher(buffer lane 0).
  - data_out_valid = 1. Data is held stable until data_out_ready=1.
- Transfer (data_out_valid && data_out_ready):
  - Buffer shifts by one lane.
  - word_counter decrements by 1.
  - remaining decrements by min(remaining, W).
- Final word (remaining <= W):
  - last_output_word = 1.
  - valid_bytes = remaining[6:3]; the value 64 maps to 8.
  - Bytes beyond valid_bytes are forced to 0 (LSB side of data_out).
- Other words: valid_bytes = 8 and last_output_word = 0.
- After a transfer:
  - If it was the final word, go to DONE.
  - Else if word_counter reaches 0, pulse block_request for 1 cycle, then go to WAIT_BLOCK.
  - Otherwise stay in SHIFT.
- DONE: pulse done for 1 cycle, then go to IDLE. busy drops the same cycle.
- Boundary conditions:
  - Request ends exactly on a block boundary: no block_request is issued. done takes priority.
  - size_load outside IDLE is ignored.
  - block_valid outside WAIT_BLOCK is ignored.
  - data_out_ready may be held high continuously, giving one word per cycle.
  - A ready deassert must not drop valid or alter the data.
  - Reset mid-operation aborts immediately. No done pulse is produced.
  - Counters saturate at 0 and never wrap.

Decomposition:
- Shared package keccak_pkg gets:
  - dump_state_t enum (IDLE, WAIT_BLOCK, SHIFT, DONE).
  - SHAKE128_WORDS=21 and SHAKE256_WORDS=17 constants.
- Reuses RATE_SHAKE128, w, the mode vectors and EndianSwitcher from keccak_pkg.
- One sub-module: piso_buffer (WIDTH=W, DEPTH=RATE/W), with parallel load, shift-on-enable, lane 0 output, and the same asynchronous active-low reset.
- The remaining-size counter is reused as size_counter where compatible with the reset convention; otherwise it is built inline.

Test Plan:
- SHAKE128, output_size=256:
  - Expect 4 words with valid_bytes=8.
  - last_output_word=1 on word 4, then a done pulse.
  - No block_request.
- SHAKE256, output_size=1096:
  - 17 full words, then one block_request pulse.
  - After block_valid: 1 word with valid_bytes=1, data_out[55:0]=0, last_output_word=1, then done.
- SHAKE128, output_size=1344 (exactly one block):
  - 21 words, no block_request, done after word 21.
- Backpressure:
  - Toggle data_out_ready with a random 50% pattern.
  - data_out_valid stays high and data_out stays stable between transfers.
  - Word sequence is identical to the no-stall run.
- output_size=0 and output_size=5:
  - Both go IDLE→DONE, with done one cycle after size_load.
  - No data_out_valid and no block_request.
- rst pulled to 0 mid-block (word 9 of 17):
  - All outputs are 0 asynchronously, FSM is IDLE, busy=0.
  - A fresh size_load then runs normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants, mode encodings and helpers.
// The dump datapath uses them to serialize squeezed rate blocks.
package keccak_pkg;

    localparam int w             = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b01;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b10;

    localparam int SHAKE128_WORDS = RATE_SHAKE128 / w;
    localparam int SHAKE256_WORDS = RATE_SHAKE256 / w;

    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, SHIFT, DONE} dump_state_t;

    // Keccak lanes are little-endian; the stream carries its first byte in the MSB.
    function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] x);
        logic [w-1:0] y;
        for (int i = 0; i < w / 8; i++)
            y[8*i +: 8] = x[w-8-8*i +: 8];
        return y;
    endfunction

    function automatic logic [4:0] dump_max_words(input logic [1:0] mode);
        return (mode == SHAKE256_MODE_VEC) ? 5'(SHAKE256_WORDS) : 5'(SHAKE128_WORDS);
    endfunction

endpackage

// File: rtl/dump_datapath_if.sv
// Output word stream of the dump datapath: valid/ready plus byte-count and last flag.
interface dump_datapath_if import keccak_pkg::*; #(parameter int W = w);

    logic [W-1:0] data_out;
    logic         data_out_valid;
    logic         data_out_ready;
    logic [3:0]   valid_bytes;
    logic         last_output_word;

    modport master (
        output data_out, data_out_valid, valid_bytes, last_output_word,
        input  data_out_ready
    );

    modport slave (
        input  data_out, data_out_valid, valid_bytes, last_output_word,
        output data_out_ready
    );

endinterface

// File: rtl/piso_buffer.sv
// Parallel-in serial-out lane buffer: load a whole block, shift one lane per enable.
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   shift,
    input  logic [DEPTH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]       dout
);

    logic [DEPTH-1:0][WIDTH-1:0] lanes;

    // Load wins over shift; vacated top lanes fill with zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lanes <= '0;
        else if (load)
            lanes <= din;
        else if (shift)
            lanes <= {{WIDTH{1'b0}}, lanes[DEPTH-1:1]};
    end

    assign dout = lanes[0];

endmodule

// File: rtl/dump_datapath.sv
// Serializes squeezed rate blocks into W-bit stream words, masks the final
// partial word and requests further blocks until the requested length is emitted.
module dump_datapath import keccak_pkg::*; #(
    parameter int W    = w,
    parameter int RATE = RATE_SHAKE128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            size_load,
    input  logic [31:0]     output_size,
    input  logic [1:0]      operation_mode,
    input  logic            block_valid,
    input  logic [RATE-1:0] state_in,
    output logic            block_request,
    output logic            busy,
    output logic            done,
    dump_datapath_if.master out_if
);

    localparam int DEPTH  = RATE / W;
    localparam int NBYTES = W / 8;

    dump_state_t state, state_nxt;
    logic [31:0] remaining;
    logic [1:0]  mode;
    logic [4:0]  word_counter;
    logic [W-1:0] lane0, swapped;
    logic [3:0]  vb;
    logic        xfer, load_blk, final_word, block_end;
    logic        unused_size_lsbs;

    assign unused_size_lsbs = ^output_size[2:0];

    assign xfer       = (state == SHIFT) && out_if.data_out_ready;
    assign load_blk   = (state == WAIT_BLOCK) && block_valid;
    assign final_word = (remaining <= 32'(W));
    assign block_end  = (word_counter <= 5'd1);
    assign swapped    = EndianSwitcher(lane0);
    assign vb         = final_word ? remaining[6:3] : 4'(NBYTES);

    piso_buffer #(.WIDTH(W), .DEPTH(DEPTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_blk),
        .shift (xfer),
        .din   (state_in[DEPTH*W-1:0]),
        .dout  (lane0)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (size_load)
                            state_nxt = (output_size[31:3] == '0) ? DONE : WAIT_BLOCK;
            WAIT_BLOCK: if (block_valid) state_nxt = SHIFT;
            // Final word outranks the block boundary: no block is requested at the end.
            SHIFT:      if (xfer) begin
                            if (final_word)     state_nxt = DONE;
                            else if (block_end) state_nxt = WAIT_BLOCK;
                        end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining     <= '0;
            mode          <= '0;
            word_counter  <= '0;
            block_request <= 1'b0;
        end else begin
            block_request <= xfer && !final_word && block_end;
            if (state == IDLE && size_load) begin
                remaining <= {output_size[31:3], 3'b000};
                mode      <= operation_mode;
            end else if (xfer) begin
                remaining <= final_word ? '0 : remaining - 32'(W);
            end
            if (load_blk)
                word_counter <= dump_max_words(mode);
            else if (xfer && word_counter != '0)
                word_counter <= word_counter - 5'd1;
        end
    end

    always_comb begin
        busy                    = (state != IDLE);
        done                    = (state == DONE);
        out_if.data_out_valid   = (state == SHIFT);
        out_if.last_output_word = (state == SHIFT) && final_word;
        out_if.valid_bytes      = (state == SHIFT) ? vb : 4'd0;
        out_if.data_out         = '0;
        for (int b = 0; b < NBYTES; b++)
            if (state == SHIFT && b < int'(vb))
                out_if.data_out[W-1-8*b -: 8] = swapped[W-1-8*b -: 8];
    end

endmodule
